fe_modexp_ctrl: RTL and testbench
=================================

Name: fe_modexp_ctrl

Overview:
Sequencer that computes result = base^exponent mod p (p = 2^255-19) by driving one external 255-bit modular multiplier (multiplier_255bit, ports in1/in2/clk/rst/out) with a constant-time left-to-right square-and-multiply schedule. It owns the multiplier operand buses, waits a fixed pipeline latency per product, and exposes a start/ready/done handshake to the upper layer. Field inversion uses exponent = p-2.

Parameters:
WIDTH, 255, field element width (operands, result, multiplier buses)
EXP_WIDTH, 255, exponent bits processed; always all bits, MSB first
MUL_LATENCY, 4, cycles operands are held stable before mul_out is sampled (>=1)

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request; accepted only when ready=1
base  input  WIDTH  base operand, fully reduced (< p); latched on accept
exponent  input  EXP_WIDTH  exponent; latched on accept
ready  output  1  high in IDLE only
done  output  1  one-cycle pulse, result valid
result  output  WIDTH  final power; held until next accepted start
mul_in1  output  WIDTH  multiplier operand 1 (registered)
mul_in2  output  WIDTH  multiplier operand 2 (registered)
mul_out  input  WIDTH  multiplier product, reduced mod p

Behaviour:
- Reset (rst=1 at edge): state IDLE; ready=1, done=0, result=0, mul_in1=mul_in2=0, wait counter=0, bit index=EXP_WIDTH-1. Reset mid-operation aborts immediately; no done pulse.
- States: IDLE, SQR, MUL, DONE.
- IDLE: start=1 at edge -> latch base_r, exp_r; acc=1; idx=EXP_WIDTH-1; cnt=0; go SQR. start while not IDLE is ignored (no queueing, no latch).
- SQR: mul_in1=mul_in2=acc. cnt increments each cycle; on edge with cnt=MUL_LATENCY-1: acc<=mul_out, cnt<=0, go MUL.
- MUL: mul_in1=acc, mul_in2=base_r. On edge with cnt=MUL_LATENCY-1: if exp_r[idx]=1 acc<=mul_out else acc unchanged (product discarded; multiply always issued -> timing independent of exponent). cnt<=0. If idx=0 -> result<=selected acc, go DONE; else idx<=idx-1, go SQR.
- DONE: done=1 for exactly this cycle, ready=0; next edge -> IDLE. mul_in1/mul_in2 return to 0 in IDLE and DONE.
- Operand buses change only on state transitions; held constant for every one of the MUL_LATENCY cycles of a product.
- Latency: done is high in the cycle following edge E0 + 2*EXP_WIDTH*MUL_LATENCY, where E0 is the accept edge; identical for every exponent. Default: 2040 cycles. Back-to-back: next start accepted no earlier than one cycle after done.
- Edge cases: exponent=0 -> result=1; base=0, exponent!=0 -> result=0; base=1 -> result=1. No modular reduction performed here; mul_out trusted reduced.
- ready deasserts on the accept edge; start and rst together -> rst wins.

Test Plan:
- Reset: rst=1 for 5 cycles, release -> ready=1, done=0, result=0, mul_in1=mul_in2=0.
- Small power: base=3, exponent=5, behavioural mod-p multiplier latency 4 -> done exactly 2040 cycles after accept, result=0xf3; done high one cycle only.
- Inversion: base=2, exponent=p-2 -> result=(p+1)/2 = 0x3fff...fff7 (2^254-9); base=0x7fff...ffec (p-1), exponent=p-2 -> result=p-1.
- Boundaries: exponent=0 -> result=1; base=0, exponent=1 -> result=0; Fermat base=0x1234, exponent=p-1 -> result=1; all with identical 2040-cycle latency.
- Handshake: second start pulsed mid-run with different operands -> ignored, first result unchanged; start held high through done -> new op accepted in the IDLE cycle after DONE.
- Abort: rst asserted 700 cycles into a run -> next cycle IDLE, no done pulse, result=0; a subsequent start runs to correct result. Repeat with MUL_LATENCY=1 -> latency 510 cycles.

Source files
------------

// File: rtl/fe_modexp_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fe_modexp_ctrl
// Brief    : Constant-time square-and-multiply sequencer computing
//            base^exponent mod (2^255-19) on an external modular multiplier.
// Revision : 1.0 - initial release
// ============================================================================
module fe_modexp_ctrl #(
    parameter int WIDTH       = 255,
    parameter int EXP_WIDTH   = 255,
    parameter int MUL_LATENCY = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     base,
    input  logic [EXP_WIDTH-1:0] exponent,
    output logic                 ready,
    output logic                 done,
    output logic [WIDTH-1:0]     result,
    output logic [WIDTH-1:0]     mul_in1,
    output logic [WIDTH-1:0]     mul_in2,
    input  logic [WIDTH-1:0]     mul_out
);

    localparam int CW = (MUL_LATENCY > 1) ? $clog2(MUL_LATENCY) : 1;
    localparam int IW = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;

    localparam logic [CW-1:0]    c_cnt_last = CW'(MUL_LATENCY - 1);
    localparam logic [IW-1:0]    c_idx_top  = IW'(EXP_WIDTH - 1);
    localparam logic [WIDTH-1:0] c_one      = WIDTH'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SQR  = 2'd1,
        ST_MUL  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t               r_state;
    logic [WIDTH-1:0]     r_base;
    logic [EXP_WIDTH-1:0] r_exp;
    logic [WIDTH-1:0]     r_acc;
    logic [CW-1:0]        r_cnt;
    logic [IW-1:0]        r_idx;

    logic                 w_last;
    logic [WIDTH-1:0]     w_mul_sel;

    assign w_last    = (r_cnt == c_cnt_last);
    // The multiply is always issued; a zero exponent bit simply discards the product.
    assign w_mul_sel = r_exp[r_idx] ? mul_out : r_acc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_base  <= '0;
            r_exp   <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_idx   <= c_idx_top;
            ready   <= 1'b1;
            done    <= 1'b0;
            result  <= '0;
            mul_in1 <= '0;
            mul_in2 <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        r_base  <= base;
                        r_exp   <= exponent;
                        r_acc   <= c_one;
                        r_idx   <= c_idx_top;
                        r_cnt   <= '0;
                        mul_in1 <= c_one;
                        mul_in2 <= c_one;
                        ready   <= 1'b0;
                        r_state <= ST_SQR;
                    end
                end

                ST_SQR: begin
                    if (w_last) begin
                        r_acc   <= mul_out;
                        r_cnt   <= '0;
                        mul_in1 <= mul_out;
                        mul_in2 <= r_base;
                        r_state <= ST_MUL;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                ST_MUL: begin
                    if (w_last) begin
                        r_acc <= w_mul_sel;
                        r_cnt <= '0;
                        if (r_idx == '0) begin
                            result  <= w_mul_sel;
                            done    <= 1'b1;
                            mul_in1 <= '0;
                            mul_in2 <= '0;
                            r_state <= ST_DONE;
                        end else begin
                            r_idx   <= r_idx - 1'b1;
                            mul_in1 <= w_mul_sel;
                            mul_in2 <= w_mul_sel;
                            r_state <= ST_SQR;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                ST_DONE: begin
                    done    <= 1'b0;
                    ready   <= 1'b1;
                    r_state <= ST_IDLE;
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fe_modexp_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fe_modexp_ctrl
// Brief    : Self-checking bench for fe_modexp_ctrl with a mod-p multiplier model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fe_modexp_ctrl;

    localparam logic [254:0] P      = {255{1'b1}} - 255'd18;
    localparam logic [254:0] C_HALF = {1'b0, {254{1'b1}}} - 255'd8;
    localparam int           LAT4   = 2040;
    localparam int           LAT1   = 510;

    int total = 0;
    int bad   = 0;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [254:0] base = '0;
    logic [254:0] exponent = '0;
    logic         ready, done;
    logic [254:0] result, mul_in1, mul_in2, mul_out;

    logic         rst_b = 1'b1;
    logic         start_b = 1'b0;
    logic [254:0] base_b = '0;
    logic [254:0] exponent_b = '0;
    logic         ready_b, done_b;
    logic [254:0] result_b, mul_in1_b, mul_in2_b, mul_out_b;

    always #5 clk = ~clk;

    function automatic logic [254:0] modmul(input logic [254:0] a, input logic [254:0] b);
        logic [509:0] t;
        t = {255'b0, a} * {255'b0, b};
        t = t % {255'b0, P};
        return t[254:0];
    endfunction

    // Right-to-left binary exponentiation as an independent reference.
    function automatic logic [254:0] modexp(input logic [254:0] b, input logic [254:0] e);
        logic [254:0] r, x;
        r = 255'd1;
        x = b;
        for (int i = 0; i < 255; i++) begin
            if (e[i]) r = modmul(r, x);
            x = modmul(x, x);
        end
        return r;
    endfunction

    function automatic logic [254:0] rand255();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        if (v[254:0] >= P) return v[254:0] - P;
        return v[254:0];
    endfunction

    // Multiplier models: 4-cycle (3 pipeline registers) and combinational.
    logic [254:0] pipe [0:2];
    always @(posedge clk) begin
        pipe[0] <= modmul(mul_in1, mul_in2);
        pipe[1] <= pipe[0];
        pipe[2] <= pipe[1];
    end
    assign mul_out   = pipe[2];
    assign mul_out_b = modmul(mul_in1_b, mul_in2_b);

    fe_modexp_ctrl #(.WIDTH(255), .EXP_WIDTH(255), .MUL_LATENCY(4)) dut (
        .clk(clk), .rst(rst), .start(start), .base(base), .exponent(exponent),
        .ready(ready), .done(done), .result(result),
        .mul_in1(mul_in1), .mul_in2(mul_in2), .mul_out(mul_out)
    );

    fe_modexp_ctrl #(.WIDTH(255), .EXP_WIDTH(255), .MUL_LATENCY(1)) dut_b (
        .clk(clk), .rst(rst_b), .start(start_b), .base(base_b), .exponent(exponent_b),
        .ready(ready_b), .done(done_b), .result(result_b),
        .mul_in1(mul_in1_b), .mul_in2(mul_in2_b), .mul_out(mul_out_b)
    );

    task automatic issue(input logic [254:0] b, input logic [254:0] e);
        @(negedge clk);
        start = 1'b1; base = b; exponent = e;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (done !== 1'b1 && n < 3000);
    endtask

    task automatic issue_b(input logic [254:0] b, input logic [254:0] e);
        @(negedge clk);
        start_b = 1'b1; base_b = b; exponent_b = e;
        @(posedge clk); #1;
        start_b = 1'b0;
    endtask

    task automatic wait_done_b(output int n);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (done_b !== 1'b1 && n < 1000);
    endtask

    task automatic test_reset();
        repeat (5) @(posedge clk);
        @(negedge clk); rst = 1'b0; rst_b = 1'b0;
        @(posedge clk); #1;
        total++; if (ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", ready); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
        total++; if (result !== '0) begin bad++; $display("FAIL reset_result got=%h want=0", result); end
        total++; if ({mul_in1, mul_in2} !== '0) begin bad++; $display("FAIL reset_mulin got=%h/%h want=0", mul_in1, mul_in2); end
        total++; if ({ready_b, done_b} !== 2'b10) begin bad++; $display("FAIL reset_b got=%b%b want=10", ready_b, done_b); end
    endtask

    task automatic test_small_power();
        int n;
        issue(255'd3, 255'd5);
        total++; if (ready !== 1'b0) begin bad++; $display("FAIL accept_ready got=%b want=0", ready); end
        total++; if (mul_in1 !== 255'd1 || mul_in2 !== 255'd1) begin bad++; $display("FAIL first_square got=%h/%h want=1/1", mul_in1, mul_in2); end
        wait_done(n);
        total++; if (n !== LAT4) begin bad++; $display("FAIL small_latency got=%0d want=%0d", n, LAT4); end
        total++; if (result !== 255'hf3) begin bad++; $display("FAIL small_result got=%h want=f3", result); end
        @(posedge clk); #1;
        total++; if ({done, ready} !== 2'b01) begin bad++; $display("FAIL small_pulse got=%b%b want=01", done, ready); end
        total++; if ({mul_in1, mul_in2} !== '0) begin bad++; $display("FAIL idle_mulin got=%h/%h want=0", mul_in1, mul_in2); end
    endtask

    task automatic test_inversion();
        logic [254:0] bs [2];
        logic [254:0] ex [2];
        int n;
        bs[0] = 255'd2;  ex[0] = C_HALF;
        bs[1] = P - 1;   ex[1] = P - 1;
        for (int i = 0; i < 2; i++) begin
            issue(bs[i], P - 2);
            wait_done(n);
            total++; if (n !== LAT4) begin bad++; $display("FAIL inv_latency[%0d] got=%0d want=%0d", i, n, LAT4); end
            total++; if (result !== ex[i]) begin bad++; $display("FAIL inv_result[%0d] got=%h want=%h", i, result, ex[i]); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_boundaries();
        logic [254:0] bs [3];
        logic [254:0] es [3];
        logic [254:0] ex [3];
        int n;
        bs[0] = rand255(); es[0] = '0;     ex[0] = 255'd1;
        bs[1] = '0;        es[1] = 255'd1; ex[1] = '0;
        bs[2] = 255'h1234; es[2] = P - 1;  ex[2] = 255'd1;
        for (int i = 0; i < 3; i++) begin
            issue(bs[i], es[i]);
            wait_done(n);
            total++; if (n !== LAT4) begin bad++; $display("FAIL bound_latency[%0d] got=%0d want=%0d", i, n, LAT4); end
            total++; if (result !== ex[i]) begin bad++; $display("FAIL bound_result[%0d] got=%h want=%h", i, result, ex[i]); end
            @(posedge clk); #1;
            total++; if ({done, ready} !== 2'b01) begin bad++; $display("FAIL bound_pulse[%0d] got=%b%b want=01", i, done, ready); end
        end
    endtask

    task automatic test_random();
        logic [254:0] b, e, ex;
        int n;
        for (int i = 0; i < 3; i++) begin
            b = rand255(); e = rand255();
            ex = modexp(b, e);
            issue(b, e);
            wait_done(n);
            total++; if (n !== LAT4) begin bad++; $display("FAIL rand_latency[%0d] got=%0d want=%0d", i, n, LAT4); end
            total++; if (result !== ex) begin bad++; $display("FAIL rand_result[%0d] got=%h want=%h", i, result, ex); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_handshake();
        logic [254:0] b1, e1, b2, e2, b3, e3;
        int n;
        b1 = rand255(); e1 = rand255();
        b2 = rand255(); e2 = rand255();
        b3 = rand255(); e3 = rand255();
        // A start mid-run must be ignored.
        issue(b1, e1);
        repeat (500) @(posedge clk);
        @(negedge clk); start = 1'b1; base = b2; exponent = e2;
        @(posedge clk); #1; start = 1'b0;
        wait_done(n);
        total++; if (n !== LAT4 - 501) begin bad++; $display("FAIL ignore_latency got=%0d want=%0d", n, LAT4 - 501); end
        total++; if (result !== modexp(b1, e1)) begin bad++; $display("FAIL ignore_result got=%h want=%h", result, modexp(b1, e1)); end
        @(posedge clk); #1;
        // start held high across a whole run and through DONE.
        @(negedge clk); start = 1'b1; base = b2; exponent = e2;
        @(posedge clk); #1;
        total++; if (ready !== 1'b0) begin bad++; $display("FAIL hold_accept got=%b want=0", ready); end
        wait_done(n);
        total++; if (n !== LAT4) begin bad++; $display("FAIL hold_latency got=%0d want=%0d", n, LAT4); end
        total++; if (result !== modexp(b2, e2)) begin bad++; $display("FAIL hold_result got=%h want=%h", result, modexp(b2, e2)); end
        @(negedge clk); base = b3; exponent = e3;
        @(posedge clk); #1;
        total++; if (ready !== 1'b1) begin bad++; $display("FAIL hold_idle got=%b want=1", ready); end
        @(posedge clk); #1;
        total++; if (ready !== 1'b0) begin bad++; $display("FAIL hold_reaccept got=%b want=0", ready); end
        start = 1'b0;
        wait_done(n);
        total++; if (n !== LAT4) begin bad++; $display("FAIL hold2_latency got=%0d want=%0d", n, LAT4); end
        total++; if (result !== modexp(b3, e3)) begin bad++; $display("FAIL hold2_result got=%h want=%h", result, modexp(b3, e3)); end
        @(posedge clk); #1;
    endtask

    task automatic test_abort();
        logic [254:0] b, e;
        int n, seen;
        b = rand255(); e = rand255();
        seen = 0;
        issue(b, e);
        repeat (699) begin
            @(posedge clk); #1;
            if (done) seen++;
        end
        total++; if (seen !== 0) begin bad++; $display("FAIL abort_early_done got=%0d want=0", seen); end
        @(negedge clk); rst = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        total++; if ({ready, done} !== 2'b10) begin bad++; $display("FAIL abort_state got=%b%b want=10", ready, done); end
        total++; if (result !== '0) begin bad++; $display("FAIL abort_result got=%h want=0", result); end
        total++; if ({mul_in1, mul_in2} !== '0) begin bad++; $display("FAIL abort_mulin got=%h/%h want=0", mul_in1, mul_in2); end
        @(negedge clk); rst = 1'b0; start = 1'b0;
        b = rand255(); e = rand255();
        issue(b, e);
        wait_done(n);
        total++; if (n !== LAT4) begin bad++; $display("FAIL post_abort_latency got=%0d want=%0d", n, LAT4); end
        total++; if (result !== modexp(b, e)) begin bad++; $display("FAIL post_abort_result got=%h want=%h", result, modexp(b, e)); end
        @(posedge clk); #1;
    endtask

    task automatic test_lat1();
        logic [254:0] b, e;
        int n, seen;
        b = rand255(); e = rand255();
        issue_b(b, e);
        wait_done_b(n);
        total++; if (n !== LAT1) begin bad++; $display("FAIL lat1_latency got=%0d want=%0d", n, LAT1); end
        total++; if (result_b !== modexp(b, e)) begin bad++; $display("FAIL lat1_result got=%h want=%h", result_b, modexp(b, e)); end
        @(posedge clk); #1;
        total++; if ({done_b, ready_b} !== 2'b01) begin bad++; $display("FAIL lat1_pulse got=%b%b want=01", done_b, ready_b); end
        seen = 0;
        issue_b(rand255(), rand255());
        repeat (199) begin
            @(posedge clk); #1;
            if (done_b) seen++;
        end
        @(negedge clk); rst_b = 1'b1;
        @(posedge clk); #1;
        total++; if (seen !== 0 || {ready_b, done_b} !== 2'b10 || result_b !== '0) begin
            bad++; $display("FAIL lat1_abort got=%0d/%b%b/%h want=0/10/0", seen, ready_b, done_b, result_b);
        end
        @(negedge clk); rst_b = 1'b0;
        b = rand255(); e = 255'd5;
        issue_b(b, e);
        wait_done_b(n);
        total++; if (n !== LAT1) begin bad++; $display("FAIL lat1_post_latency got=%0d want=%0d", n, LAT1); end
        total++; if (result_b !== modexp(b, e)) begin bad++; $display("FAIL lat1_post_result got=%h want=%h", result_b, modexp(b, e)); end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_small_power();
        test_inversion();
        test_boundaries();
        test_random();
        test_handshake();
        test_abort();
        test_lat1();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
